// File: rtl/microwave_pkg.sv
// Shared microwave definitions: state codes, default timing constants and saturating time helpers.
// Also used by the display controller to decode the mode output.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_SET    = 3'b001,
    ST_RUN    = 3'b010,
    ST_STOP   = 3'b011,
    ST_FINISH = 3'b100
  } state_t;

  localparam int DEF_STEP_S   = 10;
  localparam int DEF_MAX_TIME = 9999;
  localparam int TIME_W       = 14;
  // One extra bit so a sum above the ceiling is seen before it is clipped.
  localparam int CALC_W       = 15;

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] t,
                                                input int step,
                                                input int max_t);
    logic [CALC_W-1:0] sum;
    sum = {1'b0, t} + CALC_W'(step);
    if (sum > CALC_W'(max_t)) return TIME_W'(max_t);
    return sum[TIME_W-1:0];
  endfunction

  function automatic logic [TIME_W-1:0] sat_sub(input logic [TIME_W-1:0] t,
                                                input int step);
    logic [CALC_W-1:0] diff;
    if ({1'b0, t} <= CALC_W'(step)) return '0;
    diff = {1'b0, t} - CALC_W'(step);
    return diff[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/microwave_tick_gen.sv
// One-second prescaler: counts 0..CLK_FREQ-1 while enabled and pulses tick_o on the last count.
// Held at zero whenever disabled or cleared.
module microwave_tick_gen #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

  logic [CW-1:0] count_q;

  assign tick_o = enable_i && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear_i || !enable_i) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/microwave_timer_fsm.sv
// Microwave countdown controller: IDLE/SET/RUN/STOP/FINISH with saturating time entry.
// Optional door interlock enabled by defining MW_DOOR_INTERLOCK_EN.
module microwave_timer_fsm
  import microwave_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int STEP_S        = DEF_STEP_S,
  parameter int MAX_TIME      = DEF_MAX_TIME,
  parameter int FINISH_HOLD_S = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              door_open,
  output logic [2:0]        mode,
  output logic [TIME_W-1:0] time_data,
  output logic              done
);

  localparam int HOLD_W = (FINISH_HOLD_S > 1) ? $clog2(FINISH_HOLD_S + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FINISH_HOLD_S - 1);

  state_t            state_q;
  logic [TIME_W-1:0] time_q;
  logic              done_q;
  logic [HOLD_W-1:0] hold_q;
  logic              tick;

  logic start_req;
  logic door_stop;

`ifdef MW_DOOR_INTERLOCK_EN
  assign start_req = btn_start & ~door_open;
  assign door_stop = door_open;
`else
  logic unused_door;
  assign unused_door = door_open;
  assign start_req   = btn_start;
  assign door_stop   = 1'b0;
`endif

  // Only the highest-priority button acts: stop > start > up > down.
  logic stop_w, start_w, up_w, down_w;
  assign stop_w  = btn_stop;
  assign start_w = start_req & ~btn_stop;
  assign up_w    = btn_up & ~btn_stop & ~start_req;
  assign down_w  = btn_down & ~btn_stop & ~start_req & ~btn_up;

  logic presc_en, presc_clr, any_btn;
  assign presc_en  = (state_q == ST_RUN) || (state_q == ST_FINISH);
  assign presc_clr = start_w && ((state_q == ST_SET) || (state_q == ST_STOP));
  assign any_btn   = btn_up | btn_down | btn_start | btn_stop;

  microwave_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .enable_i (presc_en),
    .clear_i  (presc_clr),
    .tick_o   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      done_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          time_q <= '0;
          hold_q <= '0;
          if (up_w) begin
            state_q <= ST_SET;
            time_q  <= sat_add('0, STEP_S, MAX_TIME);
          end
        end
        ST_SET: begin
          if (stop_w) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
          end else if (start_w) begin
            if (time_q != '0) state_q <= ST_RUN;
          end else if (up_w) begin
            time_q <= sat_add(time_q, STEP_S, MAX_TIME);
          end else if (down_w) begin
            time_q <= sat_sub(time_q, STEP_S);
            if (sat_sub(time_q, STEP_S) == '0) state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop_w || door_stop) begin
            state_q <= ST_STOP;
          end else if (up_w) begin
            // A coinciding tick is folded into the add, so FINISH cannot occur here.
            if (tick) time_q <= sat_add(time_q - TIME_W'(1), STEP_S, MAX_TIME);
            else      time_q <= sat_add(time_q, STEP_S, MAX_TIME);
          end else if (tick) begin
            if (time_q <= TIME_W'(1)) begin
              state_q <= ST_FINISH;
              time_q  <= '0;
              done_q  <= 1'b1;
              hold_q  <= '0;
            end else begin
              time_q <= time_q - TIME_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (stop_w) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
          end else if (start_w) begin
            if (time_q != '0) state_q <= ST_RUN;
          end else if (up_w) begin
            time_q <= sat_add(time_q, STEP_S, MAX_TIME);
          end else if (down_w) begin
            time_q <= sat_sub(time_q, STEP_S);
          end
        end
        ST_FINISH: begin
          time_q <= '0;
          if (any_btn) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
          end else if (tick) begin
            if (hold_q == HOLD_LAST) begin
              state_q <= ST_IDLE;
              hold_q  <= '0;
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          time_q  <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign mode      = state_q;
  assign time_data = time_q;
  assign done      = done_q;

endmodule
